// File: rtl/smooth_window_stats_pkg.sv
// smooth_window_stats_pkg: shared widths, output FSM states, window-result type and signed max/min helper.
package smooth_window_stats_pkg;
  localparam int WIDTH = 8;
  localparam int WIN_LOG2 = 3;
  localparam int SUM_W = WIDTH + WIN_LOG2;
  localparam logic signed [WIDTH-1:0] THRESH = WIDTH'(32);
  typedef enum logic {EMPTY, FULL} out_state_t;
  typedef struct packed {
    logic signed [WIDTH-1:0] max;
    logic signed [WIDTH-1:0] min;
    logic signed [SUM_W-1:0] sum;
    logic hit;
  } win_res_t;
  function automatic logic signed [WIDTH-1:0] pick(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b,
                                                   input logic want_max);
    return want_max ? ((a > b) ? a : b) : ((a < b) ? a : b);
  endfunction
endpackage

// File: rtl/smooth_window_stats_if.sv
// smooth_window_stats_if: sample input and window-result valid/ready port.
interface smooth_window_stats_if;
  import smooth_window_stats_pkg::*;
  logic ce;
  logic signed [WIDTH-1:0] din;
  logic res_valid;
  logic res_ready;
  logic signed [WIDTH-1:0] res_max;
  logic signed [WIDTH-1:0] res_min;
  logic signed [SUM_W-1:0] res_sum;
  logic res_hit;
  logic overrun;
  logic clr_overrun;
  modport slave(input ce, din, res_ready, clr_overrun,
                output res_valid, res_max, res_min, res_sum, res_hit, overrun);
  modport master(output ce, din, res_ready, clr_overrun,
                 input res_valid, res_max, res_min, res_sum, res_hit, overrun);
endinterface

// File: rtl/smooth_window_stats_accum.sv
// smooth_window_stats_accum: per-window max/min/sum accumulation; res_o already includes the current sample.
module smooth_window_stats_accum
  import smooth_window_stats_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ce_i,
  input  logic signed [WIDTH-1:0] din_i,
  output logic win_done_o,
  output win_res_t res_o
);
  logic [WIN_LOG2-1:0] cnt_q;
  logic signed [WIDTH-1:0] acc_max_q, acc_min_q;
  logic signed [SUM_W-1:0] acc_sum_q;
  logic signed [WIDTH-1:0] max_d, min_d;
  logic signed [SUM_W-1:0] sum_d, din_x;
  logic first;
  always_comb begin
    first = cnt_q == '0;
    din_x = {{WIN_LOG2{din_i[WIDTH-1]}}, din_i};
    max_d = first ? din_i : pick(acc_max_q, din_i, 1'b1);
    min_d = first ? din_i : pick(acc_min_q, din_i, 1'b0);
    sum_d = first ? din_x : acc_sum_q + din_x;
    res_o = '{max: max_d, min: min_d, sum: sum_d, hit: max_d >= THRESH};
  end
  assign win_done_o = ce_i && cnt_q == '1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      acc_max_q <= '0;
      acc_min_q <= '0;
      acc_sum_q <= '0;
    end else if (ce_i) begin
      cnt_q <= cnt_q + WIN_LOG2'(1);
      acc_max_q <= max_d;
      acc_min_q <= min_d;
      acc_sum_q <= sum_d;
    end
endmodule

// File: rtl/smooth_window_stats.sv
// smooth_window_stats: windowed max/min/sum/threshold stats on the smoothed stream, one-deep result buffer with overrun flag.
module smooth_window_stats
  import smooth_window_stats_pkg::*;
(
  input logic clk,
  input logic rst_n,
  smooth_window_stats_if.slave bus
);
  out_state_t state_q;
  win_res_t res_q, merged;
  logic overrun_q, done, cap, drop;
  smooth_window_stats_accum u_accum (
    .clk(clk),
    .rst_n(rst_n),
    .ce_i(bus.ce),
    .din_i(bus.din),
    .win_done_o(done),
    .res_o(merged)
  );
  // A completing window is captured if the slot is free or being freed this cycle.
  assign cap = done && (state_q == EMPTY || bus.res_ready);
  assign drop = done && state_q == FULL && !bus.res_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      res_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (cap) res_q <= merged;
      state_q <= (cap || (state_q == FULL && !bus.res_ready)) ? FULL : EMPTY;
      overrun_q <= drop || (overrun_q && !bus.clr_overrun);
    end
  assign bus.res_valid = state_q == FULL;
  assign bus.res_max = res_q.max;
  assign bus.res_min = res_q.min;
  assign bus.res_sum = res_q.sum;
  assign bus.res_hit = res_q.hit;
  assign bus.overrun = overrun_q;
endmodule
